// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the 1-cycle ALU result and buffered load results onto the single register-file write port.
// Optional define WB_PENDING_CHECK_EN adds ChkRS/ChkRT -> PendRS/PendRT pending-write lookups for decode stalls.
module writeback_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluRD,
    input  logic [DATA_W-1:0] AluData,
    input  logic              LoadValid,
    input  logic [ADDR_W-1:0] LoadRD,
    input  logic [DATA_W-1:0] LoadData,
    output logic              LoadReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData
`ifdef WB_PENDING_CHECK_EN
    ,
    input  logic [ADDR_W-1:0] ChkRS,
    input  logic [ADDR_W-1:0] ChkRT,
    output logic              PendRS,
    output logic              PendRT
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [DEPTH-1:0]  fifo_kill_q, fifo_kill_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic load_acc, push, push_kill, pop;

    assign LoadReady = !Reset && (count_q < DEPTH_C);
    assign load_acc  = LoadValid && LoadReady;

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        fifo_kill_d = fifo_kill_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        push        = 1'b0;
        push_kill   = 1'b0;
        pop         = 1'b0;

        if (AluValid) begin
            reg_write_d = 1'b1;
            rd_d        = AluRD;
            wdata_d     = AluData;
            // The ALU write is newer than anything buffered: older loads to the same register must not land.
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_rd_q[i] == AluRD) fifo_kill_d[i] = 1'b1;
            end
            push      = load_acc;
            push_kill = (LoadRD == AluRD);
        end else if (count_q != '0) begin
            pop         = 1'b1;
            reg_write_d = !fifo_kill_q[rptr_q];
            if (!fifo_kill_q[rptr_q]) begin
                rd_d    = fifo_rd_q[rptr_q];
                wdata_d = fifo_data_q[rptr_q];
            end
            push = load_acc;
        end else if (load_acc) begin
            reg_write_d = 1'b1;
            rd_d        = LoadRD;
            wdata_d     = LoadData;
        end

        if (push) begin
            fifo_rd_d[wptr_q]   = LoadRD;
            fifo_data_d[wptr_q] = LoadData;
            fifo_kill_d[wptr_q] = push_kill;
            wptr_d              = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_kill_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            fifo_kill_q <= fifo_kill_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign RD        = rd_q;
    assign WriteData = wdata_q;

`ifdef WB_PENDING_CHECK_EN
    logic pend_rs, pend_rt;
    logic [PTR_W-1:0] offset;
    logic live;

    // An entry is occupied when its distance from the read pointer is below the count.
    always_comb begin
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        offset  = '0;
        live    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rptr_q;
            live   = ({1'b0, offset} < count_q) && !fifo_kill_q[i];
            if (live && (fifo_rd_q[i] == ChkRS)) pend_rs = 1'b1;
            if (live && (fifo_rd_q[i] == ChkRT)) pend_rt = 1'b1;
        end
    end

    assign PendRS = !Reset && pend_rs;
    assign PendRT = !Reset && pend_rt;
`endif

endmodule
